// File: rtl/ram_dq_arbiter_if.sv
// ram_dq_arbiter_if: bundles the request/grant/read-return signals of the two
// requesters, the clear control and the RAM pin group into one interface.
//   slave  : the arbiter view (takes requests, drives grants and RAM pins)
//   master : the client/RAM side view (drives requests, receives grants)
interface ram_dq_arbiter_if #(
    parameter int WIDTH   = 2,
    parameter int WIDTHAD = 14
);
    // requester A
    logic               ReqA;
    logic               WeA;
    logic [WIDTHAD-1:0] AddrA;
    logic [WIDTH-1:0]   DataA;
    logic               GntA;
    logic               RdValidA;
    logic [WIDTH-1:0]   RdDataA;
    // requester B
    logic               ReqB;
    logic               WeB;
    logic [WIDTHAD-1:0] AddrB;
    logic [WIDTH-1:0]   DataB;
    logic               GntB;
    logic               RdValidB;
    logic [WIDTH-1:0]   RdDataB;
    // clear sequencer
    logic               Clear;
    logic [WIDTH-1:0]   ClearVal;
    logic               Busy;
    // RAM pins
    logic [WIDTHAD-1:0] RamAddress;
    logic [WIDTH-1:0]   RamData;
    logic               RamWE;
    logic               RamClockEn;
    logic [WIDTH-1:0]   RamQ;

    modport slave (
        input  ReqA, WeA, AddrA, DataA,
        output GntA, RdValidA, RdDataA,
        input  ReqB, WeB, AddrB, DataB,
        output GntB, RdValidB, RdDataB,
        input  Clear, ClearVal,
        output Busy,
        output RamAddress, RamData, RamWE, RamClockEn,
        input  RamQ
    );

    modport master (
        output ReqA, WeA, AddrA, DataA,
        input  GntA, RdValidA, RdDataA,
        output ReqB, WeB, AddrB, DataB,
        input  GntB, RdValidB, RdDataB,
        output Clear, ClearVal,
        input  Busy,
        input  RamAddress, RamData, RamWE, RamClockEn,
        output RamQ
    );
endinterface

// File: rtl/ram_dq_arbiter.sv
// ram_dq_arbiter: round-robin sharing of one RAM_DQ-style single-port RAM
// (registered address/data, unregistered Q) between requesters A and B, plus
// a clear sequencer that sweeps every word to a fill value.
// Ports:
//   Clock  - clock for this block and the RAM
//   Reset  - synchronous, active-high
//   bus    - ram_dq_arbiter_if.slave: requester A/B handshakes, Clear/
//            ClearVal/Busy, and the RAM Address/Data/WE/ClockEn/Q pins
module ram_dq_arbiter #(
    parameter int WIDTH    = 2,
    parameter int WIDTHAD  = 14,
    parameter int NUMWORDS = 16384
) (
    input  logic              Clock,
    input  logic              Reset,
    ram_dq_arbiter_if.slave   bus
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [WIDTHAD-1:0] LAST_ADDR = WIDTHAD'(NUMWORDS - 1);

    state_t             state_q, state_d;
    logic [WIDTHAD-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   fill_q, fill_d;
    logic               last_b_q, last_b_d;   // 1: B was granted last
    logic               rdv_a_q, rdv_a_d;
    logic               rdv_b_q, rdv_b_d;
    logic [WIDTHAD-1:0] addr_hold_q, addr_hold_d;
    logic [WIDTH-1:0]   data_hold_q, data_hold_d;

    logic               gnt_a, gnt_b;
    logic               ram_we, ram_ce;
    logic [WIDTHAD-1:0] ram_addr;
    logic [WIDTH-1:0]   ram_data;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        last_b_d = last_b_q;
        rdv_a_d  = 1'b0;
        rdv_b_d  = 1'b0;
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        ram_we   = 1'b0;
        ram_ce   = 1'b0;
        // With no access the address/data pins just keep their last drive,
        // which avoids needless toggling on the RAM inputs.
        ram_addr = addr_hold_q;
        ram_data = data_hold_q;

        if (state_q == IDLE) begin
            // A wins when alone, or on contention when B went last.
            if (bus.ReqA && (!bus.ReqB || last_b_q))
                gnt_a = 1'b1;
            else if (bus.ReqB)
                gnt_b = 1'b1;

            if (gnt_a) begin
                ram_addr = bus.AddrA;
                ram_data = bus.DataA;
                ram_we   = bus.WeA;
                ram_ce   = 1'b1;
                last_b_d = 1'b0;
                rdv_a_d  = !bus.WeA;
            end else if (gnt_b) begin
                ram_addr = bus.AddrB;
                ram_data = bus.DataB;
                ram_we   = bus.WeB;
                ram_ce   = 1'b1;
                last_b_d = 1'b1;
                rdv_b_d  = !bus.WeB;
            end

            // The Clear cycle itself still serves a request; the sweep
            // starts on the following cycle.
            if (bus.Clear) begin
                fill_d  = bus.ClearVal;
                cnt_d   = '0;
                state_d = CLEAR;
            end
        end else begin
            ram_addr = cnt_q;
            ram_data = fill_q;
            ram_we   = 1'b1;
            ram_ce   = 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + WIDTHAD'(1);
            end
        end

        addr_hold_d = ram_addr;
        data_hold_d = ram_data;

        // Nothing may reach the RAM or the requesters while in reset.
        if (Reset) begin
            gnt_a  = 1'b0;
            gnt_b  = 1'b0;
            ram_we = 1'b0;
            ram_ce = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_q      <= '0;
            last_b_q    <= 1'b1;
            rdv_a_q     <= 1'b0;
            rdv_b_q     <= 1'b0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            last_b_q    <= last_b_d;
            rdv_a_q     <= rdv_a_d;
            rdv_b_q     <= rdv_b_d;
            addr_hold_q <= addr_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

    assign bus.GntA       = gnt_a;
    assign bus.GntB       = gnt_b;
    assign bus.RdValidA   = rdv_a_q;
    assign bus.RdValidB   = rdv_b_q;
    // RAM Q is already one cycle behind the registered address, so it lines
    // up with the registered valid flag without further staging.
    assign bus.RdDataA    = bus.RamQ;
    assign bus.RdDataB    = bus.RamQ;
    assign bus.Busy       = (state_q == CLEAR);
    assign bus.RamAddress = ram_addr;
    assign bus.RamData    = ram_data;
    assign bus.RamWE      = ram_we;
    assign bus.RamClockEn = ram_ce;

endmodule

// File: tb/tb_ram_dq_arbiter.sv
module tb_ram_dq_arbiter;
    localparam int WIDTH    = 2;
    localparam int WIDTHAD  = 14;
    localparam int NUMWORDS = 16384;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    ram_dq_arbiter_if #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD)) bus ();

    ram_dq_arbiter #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD), .NUMWORDS(NUMWORDS)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // RAM_DQ model: address/data registered under ClockEn, Q unregistered.
    logic [WIDTH-1:0]   mem [NUMWORDS];
    logic [WIDTHAD-1:0] ram_addr_r;
    always @(posedge Clock) begin
        if (bus.RamClockEn) begin
            ram_addr_r <= bus.RamAddress;
            if (bus.RamWE) mem[bus.RamAddress] <= bus.RamData;
        end
    end
    assign bus.RamQ = mem[ram_addr_r];

    int vecs = 0;
    int errs = 0;
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read-return scoreboard: every valid must match the oldest pending read.
    always @(negedge Clock) begin
        if (bus.RdValidA === 1'b1) begin
            if (qa.size() == 0) chk("rdvalidA_spurious", 1, 0);
            else chk("rddataA", 32'(bus.RdDataA), 32'(qa.pop_front()));
        end
        if (bus.RdValidB === 1'b1) begin
            if (qb.size() == 0) chk("rdvalidB_spurious", 1, 0);
            else chk("rddataB", 32'(bus.RdDataB), 32'(qb.pop_front()));
        end
    end

    task automatic step();
        @(posedge Clock); #1;
    endtask
    task automatic settle();
        @(negedge Clock); #1;
    endtask

    task automatic idle_reqs();
        bus.ReqA = 0; bus.ReqB = 0; bus.Clear = 0;
    endtask

    // Single uncontended access; for reads d is the expected data.
    task automatic issue(bit b, bit we, logic [WIDTHAD-1:0] a, logic [WIDTH-1:0] d);
        step();
        if (b) begin bus.ReqB = 1; bus.WeB = we; bus.AddrB = a; bus.DataB = d; end
        else   begin bus.ReqA = 1; bus.WeA = we; bus.AddrA = a; bus.DataA = d; end
        settle();
        chk(b ? "grantB" : "grantA",
            {bus.GntA, bus.GntB, bus.RamWE, bus.RamClockEn, bus.RamAddress},
            {!b, b, we, 1'b1, a});
        if (!we) begin
            if (b) qb.push_back(d); else qa.push_back(d);
        end
        step(); idle_reqs(); settle();
    endtask

    // Pulse Clear (with an A write in the same cycle), then follow the sweep
    // for stop_at cycles; a second Clear is pulsed at cycle reclear_at.
    task automatic run_clear(logic [WIDTH-1:0] val, int stop_at, int reclear_at, bit holdb);
        step();
        bus.Clear = 1; bus.ClearVal = val;
        bus.ReqA = 1; bus.WeA = 1; bus.AddrA = '0; bus.DataA = ~val;
        settle();
        chk("clear_cycle_grant", {bus.Busy, bus.GntA, bus.RamWE}, {1'b0, 1'b1, 1'b1});
        for (int i = 0; i < stop_at; i++) begin
            step();
            bus.ReqA = 0;
            bus.Clear = (i == reclear_at);
            bus.ClearVal = ~val;
            if (holdb) begin bus.ReqB = 1; bus.WeB = 0; bus.AddrB = '0; end
            settle();
            chk("clear_sweep",
                {bus.Busy, bus.RamWE, bus.RamClockEn, bus.GntA, bus.GntB, bus.RamAddress, bus.RamData},
                {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 14'(i), val});
        end
        bus.Clear = 0;
    endtask

    initial begin
        idle_reqs();
        bus.WeA = 0; bus.WeB = 0; bus.AddrA = '0; bus.AddrB = '0;
        bus.DataA = '0; bus.DataB = '0; bus.ClearVal = '0;

        // Reset: requests present but nothing may be granted or touch the RAM.
        step(); step();
        bus.ReqA = 1; bus.ReqB = 1; bus.WeA = 1;
        settle();
        chk("reset_outputs",
            {bus.GntA, bus.GntB, bus.RamWE, bus.RamClockEn, bus.Busy, bus.RdValidA, bus.RdValidB},
            7'b0);
        step(); idle_reqs(); bus.WeA = 0; Reset = 0; settle();

        // Single write then read from A.
        issue(0, 1, 14'h0005, 2'b10);
        issue(0, 0, 14'h0005, 2'b10);

        // Preload for contention; B goes last so A wins first.
        issue(0, 1, 14'h0010, 2'b01);
        issue(1, 1, 14'h0020, 2'b11);
        step();
        bus.ReqA = 1; bus.WeA = 0; bus.AddrA = 14'h0010;
        bus.ReqB = 1; bus.WeB = 0; bus.AddrB = 14'h0020;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            settle();
            chk("round_robin", {bus.GntA, bus.GntB}, {(i % 2) == 0, (i % 2) == 1});
            if ((i % 2) == 0) qa.push_back(2'b01); else qb.push_back(2'b11);
        end
        step(); idle_reqs(); settle();

        // Back-to-back write then read of the top address.
        step();
        bus.ReqA = 1; bus.WeA = 1; bus.AddrA = 14'h3FFF; bus.DataA = 2'b11;
        settle();
        chk("b2b_write", {bus.GntA, bus.RamWE, bus.RamAddress}, {1'b1, 1'b1, 14'h3FFF});
        step(); bus.WeA = 0; settle();
        chk("b2b_read", {bus.GntA, bus.RamWE, bus.RamAddress}, {1'b1, 1'b0, 14'h3FFF});
        qa.push_back(2'b11);
        step(); idle_reqs(); settle();

        // Full clear with B waiting throughout.
        run_clear(2'b01, NUMWORDS, -1, 1);
        step(); settle();
        chk("clear_done_grantB", {bus.Busy, bus.GntB, bus.RamAddress}, {1'b0, 1'b1, 14'h0000});
        qb.push_back(2'b01);
        step(); idle_reqs(); settle();
        issue(0, 0, 14'h3FFF, 2'b01);

        // Reset 100 cycles into a clear.
        run_clear(2'b10, 100, -1, 0);
        step();
        Reset = 1; bus.ReqA = 1; bus.WeA = 0; bus.AddrA = 14'h0005;
        settle();
        chk("reset_midclear", {bus.GntA, bus.GntB, bus.RamWE, bus.RamClockEn}, 4'b0);
        step(); Reset = 0; settle();
        chk("post_reset_grant", {bus.Busy, bus.GntA}, {1'b0, 1'b1});
        qa.push_back(2'b10);          // partial fill reached address 5
        step(); idle_reqs(); settle();
        issue(0, 0, 14'h3FFF, 2'b01); // beyond the partial fill

        // New clear restarts from 0; a second pulse mid-sweep is ignored.
        run_clear(2'b11, NUMWORDS, 50, 0);
        step(); settle();
        chk("clear_end_busy", {bus.Busy, bus.RamClockEn}, 2'b00);
        issue(1, 0, 14'h1234, 2'b11);

        step(); step(); settle();
        chk("pending_readsA", qa.size(), 0);
        chk("pending_readsB", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
